// File: rtl/gain_ramp_q5_8.sv
// -----------------------------------------------------------------------------
// gain_ramp_q5_8
// Multi-band gain stage for the equalizer. Per-band gain codes arrive over a
// valid/ready port, are mapped through a fixed code table to a Q(INT_W).(FRAC_W)
// gain, and each band's output gain slews toward its new target by at most
// RAMP_STEP LSBs per sample_tick so that gain changes cause no zipper noise.
//
// Configuration macro: GAIN_RAMP_EN
//   defined   : per-band ramping on sample_tick
//   undefined : no ramp logic; a band's gain jumps to its target at COMMIT,
//               sample_tick is ignored and settled is constantly all ones
//
// Ports
//   clk          in   rising-edge system clock
//   rst_n        in   asynchronous active-low reset
//   sample_tick  in   one-cycle pulse per audio sample (ramp step strobe)
//   upd_valid    in   gain update request
//   upd_ready    out  update port can accept (registered)
//   upd_band     in   target band index
//   upd_code     in   gain code
//   upd_err      out  one-cycle pulse when the band index is out of range
//   gain_out     out  current gain per band, band 0 in the LSBs (registered)
//   settled      out  bit b set when band b's current gain equals its target
// -----------------------------------------------------------------------------
module gain_ramp_q5_8 #(
  parameter int N_BANDS   = 5,
  parameter int CODE_W    = 6,
  parameter int INT_W     = 5,
  parameter int FRAC_W    = 8,
  parameter int RAMP_STEP = 16,
  localparam int BAND_W   = (N_BANDS > 1) ? $clog2(N_BANDS) : 1,
  localparam int GW       = INT_W + FRAC_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sample_tick,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [BAND_W-1:0]       upd_band,
  input  logic [CODE_W-1:0]       upd_code,
  output logic                    upd_err,
  output logic [N_BANDS*GW-1:0]   gain_out,
  output logic [N_BANDS-1:0]      settled
);

  localparam logic [GW-1:0] UNITY = GW'(2 ** FRAC_W);

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    COMMIT
  } state_t;

  state_t              state_q;
  logic [BAND_W-1:0]   band_q;
  logic [CODE_W-1:0]   code_q;
  logic [GW-1:0]       lookup_q;
  logic                upd_ready_q;
  logic                upd_err_q;
  logic                commit;

  // Code table. The attenuation range divides by a loop constant, so each
  // entry folds to a literal and the table becomes a small ROM.
  function automatic logic [GW-1:0] code_to_gain(input logic [CODE_W-1:0] code);
    int            c;
    logic [GW-1:0] g;
    c = 32'(code);
    g = '0;
    for (int k = 1; k <= 15; k++) begin
      if (c == k) begin
        g = GW'((2 ** (FRAC_W + 1) + (17 - k)) / (2 * (17 - k)));
      end
    end
    if (c >= 16 && c <= 18) begin
      g = UNITY;
    end else if (c >= 19 && c <= 33) begin
      g = GW'((c - 17) << FRAC_W);
    end
    return g;
  endfunction

  // Update handshake: accept in IDLE, register the table result in LOOKUP,
  // write the target in COMMIT. upd_err is raised for the COMMIT cycle only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      band_q      <= '0;
      code_q      <= '0;
      lookup_q    <= UNITY;
      upd_ready_q <= 1'b1;
      upd_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (upd_valid) begin
            band_q      <= upd_band;
            code_q      <= upd_code;
            upd_ready_q <= 1'b0;
            state_q     <= LOOKUP;
          end
        end
        LOOKUP: begin
          lookup_q  <= code_to_gain(code_q);
          upd_err_q <= (int'(band_q) >= N_BANDS);
          state_q   <= COMMIT;
        end
        COMMIT: begin
          upd_err_q   <= 1'b0;
          upd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          upd_err_q   <= 1'b0;
          upd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign commit    = (state_q == COMMIT);
  assign upd_ready = upd_ready_q;
  assign upd_err   = upd_err_q;

  logic [GW-1:0] cur_q [N_BANDS];
  logic [GW-1:0] cur_d [N_BANDS];

`ifdef GAIN_RAMP_EN

  localparam logic [GW-1:0] STEP_G = GW'(RAMP_STEP);
  localparam logic [GW:0]   STEP_W = (GW + 1)'(RAMP_STEP);

  logic [GW-1:0]       tgt_q [N_BANDS];
  logic [GW-1:0]       tgt_d [N_BANDS];
  logic [N_BANDS-1:0]  settled_q;
  logic [N_BANDS-1:0]  settled_d;

  // One ramp step toward tgt. The distance is measured one bit wider so the
  // comparison against the step can never wrap; the add/subtract itself only
  // happens when the step fits strictly inside the distance, so it stays in range.
  function automatic logic [GW-1:0] ramp_step(input logic [GW-1:0] cur,
                                              input logic [GW-1:0] tgt);
    logic [GW:0]   cur_w;
    logic [GW:0]   tgt_w;
    logic [GW:0]   diff_w;
    logic [GW-1:0] nxt;
    cur_w  = {1'b0, cur};
    tgt_w  = {1'b0, tgt};
    diff_w = '0;
    nxt    = cur;
    if (cur_w < tgt_w) begin
      diff_w = tgt_w - cur_w;
      nxt    = (diff_w > STEP_W) ? cur + STEP_G : tgt;
    end else if (cur_w > tgt_w) begin
      diff_w = cur_w - tgt_w;
      nxt    = (diff_w > STEP_W) ? cur - STEP_G : tgt;
    end
    return nxt;
  endfunction

  // Target write happens before the step so that a tick coinciding with
  // COMMIT already moves toward the new target.
  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      tgt_d[b] = tgt_q[b];
      if (commit && (band_q == BAND_W'(b))) begin
        tgt_d[b] = lookup_q;
      end
      cur_d[b] = cur_q[b];
      if (sample_tick) begin
        cur_d[b] = ramp_step(cur_q[b], tgt_d[b]);
      end
      settled_d[b] = (cur_d[b] == tgt_d[b]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANDS; b++) begin
        cur_q[b] <= UNITY;
        tgt_q[b] <= UNITY;
      end
      settled_q <= '1;
    end else begin
      for (int b = 0; b < N_BANDS; b++) begin
        cur_q[b] <= cur_d[b];
        tgt_q[b] <= tgt_d[b];
      end
      settled_q <= settled_d;
    end
  end

  assign settled = settled_q;

`else

  // Without ramping the step strobe and step size have no function.
  logic    unused_tick;
  localparam int unused_ramp_step = RAMP_STEP;
  assign unused_tick = sample_tick;

  // The committed gain is applied directly.
  always_comb begin
    for (int b = 0; b < N_BANDS; b++) begin
      cur_d[b] = cur_q[b];
      if (commit && (band_q == BAND_W'(b))) begin
        cur_d[b] = lookup_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < N_BANDS; b++) begin
        cur_q[b] <= UNITY;
      end
    end else begin
      for (int b = 0; b < N_BANDS; b++) begin
        cur_q[b] <= cur_d[b];
      end
    end
  end

  assign settled = '1;

`endif

  // Flatten the per-band gains, band 0 in the LSBs.
  always_comb begin
    gain_out = '0;
    for (int b = 0; b < N_BANDS; b++) begin
      gain_out[b*GW +: GW] = cur_q[b];
    end
  end

endmodule

// File: tb/tb_gain_ramp_q5_8.sv
// -----------------------------------------------------------------------------
// tb_gain_ramp_q5_8
// Self-checking bench for gain_ramp_q5_8. Every update request pushes its
// expected band/gain onto a scoreboard queue; the entry is popped into the
// bench's own band model when the DUT commits it, and the DUT outputs are
// compared against that model. Ramp scenarios are exercised when GAIN_RAMP_EN
// is defined; otherwise the table sweep and tick-ignore scenarios run.
// -----------------------------------------------------------------------------
module tb_gain_ramp_q5_8;

  localparam int NB = 5;
  localparam int GW = 13;

  typedef struct {
    int            band;
    logic [GW-1:0] gain;
  } upd_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sample_tick;
  logic              upd_valid;
  logic              upd_ready;
  logic [2:0]        upd_band;
  logic [5:0]        upd_code;
  logic              upd_err;
  logic [NB*GW-1:0]  gain_out;
  logic [NB-1:0]     settled;

  int            n_checks = 0;
  int            n_fails  = 0;
  upd_t          sb_q[$];
  logic [GW-1:0] mdl_cur [NB];
  logic [GW-1:0] mdl_tgt [NB];

  gain_ramp_q5_8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_tick (sample_tick),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_band    (upd_band),
    .upd_code    (upd_code),
    .upd_err     (upd_err),
    .gain_out    (gain_out),
    .settled     (settled)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference code table, written as quotient/remainder rounding.
  function automatic logic [GW-1:0] ref_gain(input int code);
    int q;
    int r;
    int d;
    if (code == 0 || code > 33) return '0;
    if (code <= 15) begin
      d = 17 - code;
      q = 256 / d;
      r = 256 % d;
      if (2 * r >= d) q++;
      return GW'(q);
    end
    if (code <= 18) return GW'(256);
    return GW'((code - 17) * 256);
  endfunction

  function automatic logic [GW-1:0] ref_step(input logic [GW-1:0] cur, input logic [GW-1:0] tgt);
    int c;
    int t;
    c = int'(cur);
    t = int'(tgt);
    if (c < t) return (t - c > 16) ? GW'(c + 16) : tgt;
    if (c > t) return (c - t > 16) ? GW'(c - 16) : tgt;
    return cur;
  endfunction

  function automatic logic [GW-1:0] band_gain(input int b);
    return gain_out[b*GW +: GW];
  endfunction

  function automatic logic [NB-1:0] exp_settled();
    logic [NB-1:0] s;
    for (int b = 0; b < NB; b++) s[b] = (mdl_cur[b] == mdl_tgt[b]);
    return s;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      mdl_cur[b] = GW'(256);
      mdl_tgt[b] = GW'(256);
    end
    sb_q.delete();
  endtask

  task automatic commit_model();
    upd_t u;
    if (sb_q.size() == 0) return;
    u = sb_q.pop_front();
    if (u.band < NB) begin
      mdl_tgt[u.band] = u.gain;
`ifndef GAIN_RAMP_EN
      mdl_cur[u.band] = u.gain;
`endif
    end
  endtask

  task automatic step_model();
`ifdef GAIN_RAMP_EN
    for (int b = 0; b < NB; b++) mdl_cur[b] = ref_step(mdl_cur[b], mdl_tgt[b]);
`endif
  endtask

  // Drives one request starting at posedge+1 and returns at accept edge + 1.
  task automatic applyStimulus(input int b, input int c);
    int waited = 0;
    upd_band  = 3'(b);
    upd_code  = 6'(c);
    upd_valid = 1'b1;
    @(negedge clk);
    while (upd_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (waited >= 20) begin
      n_fails++;
      $display("[TB] FAIL accept_wait band=%0d upd_ready actual=%b required=1", b, upd_ready);
    end
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
  endtask

  task automatic send_and_commit(input int b, input int c);
    sb_q.push_back('{b, ref_gain(c)});
    applyStimulus(b, c);
    repeat (2) @(posedge clk);
    #1;
    commit_model();
  endtask

  task automatic tick_once();
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    step_model();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sample_tick = 1'b0;
    upd_valid = 1'b0;
    upd_band = '0;
    upd_code = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (band_gain(b) !== 13'h100) begin
        n_fails++;
        $display("[TB] FAIL reset_gain band=%0d actual=%h required=100", b, band_gain(b));
      end
    end
    n_checks++;
    if (settled !== 5'h1F || upd_ready !== 1'b1 || upd_err !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL reset_flags settled/ready/err actual=%h/%b/%b required=1f/1/0", settled, upd_ready, upd_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_table_sweep();
    for (int c = 0; c < 64; c++) begin
      send_and_commit(0, c);
      n_checks++;
      if (band_gain(0) !== mdl_cur[0]) begin
        n_fails++;
        $display("[TB] FAIL sweep code=%0d gain actual=%0d required=%0d", c, band_gain(0), mdl_cur[0]);
      end
    end
    n_checks++;
    if (settled !== 5'h1F || band_gain(1) !== 13'd256) begin
      n_fails++;
      $display("[TB] FAIL sweep_side settled/gain1 actual=%h/%0d required=1f/256", settled, band_gain(1));
    end
  endtask

  task automatic test_tick_ignored();
    send_and_commit(1, 1);
    for (int i = 0; i < 4; i++) begin
      tick_once();
      n_checks++;
      if (band_gain(1) !== 13'd16 || settled !== 5'h1F) begin
        n_fails++;
        $display("[TB] FAIL tick_ignored gain/settled actual=%0d/%h required=16/1f", band_gain(1), settled);
      end
      repeat (3) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_ramp_up();
    send_and_commit(2, 33);
    n_checks++;
    if (band_gain(2) !== 13'd256 || settled !== exp_settled()) begin
      n_fails++;
      $display("[TB] FAIL ramp_up_start gain/settled actual=%0d/%h required=256/%h", band_gain(2), settled, exp_settled());
    end
    for (int i = 0; i < 240; i++) begin
      tick_once();
      n_checks++;
      if (band_gain(2) !== mdl_cur[2] || settled !== exp_settled()) begin
        n_fails++;
        $display("[TB] FAIL ramp_up tick=%0d gain/settled actual=%0d/%h required=%0d/%h", i, band_gain(2), settled, mdl_cur[2], exp_settled());
      end
      repeat (3) @(posedge clk);
      #1;
    end
    tick_once();
    n_checks++;
    if (band_gain(2) !== 13'd4096 || settled[2] !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL ramp_up_end gain/settled2 actual=%0d/%b required=4096/1", band_gain(2), settled[2]);
    end
  endtask

  task automatic test_ramp_down();
    send_and_commit(1, 1);
    for (int i = 0; i < 15; i++) begin
      tick_once();
      n_checks++;
      if (band_gain(1) !== mdl_cur[1] || settled !== exp_settled()) begin
        n_fails++;
        $display("[TB] FAIL ramp_down tick=%0d gain/settled actual=%0d/%h required=%0d/%h", i, band_gain(1), settled, mdl_cur[1], exp_settled());
      end
      repeat (3) @(posedge clk);
      #1;
    end
    tick_once();
    n_checks++;
    if (band_gain(1) !== 13'd16 || settled[1] !== 1'b1) begin
      n_fails++;
      $display("[TB] FAIL ramp_down_end gain/settled1 actual=%0d/%b required=16/1", band_gain(1), settled[1]);
    end
  endtask

  task automatic test_collision();
    send_and_commit(0, 33);
    for (int i = 0; i < 5; i++) begin
      tick_once();
      repeat (3) @(posedge clk);
      #1;
    end
    n_checks++;
    if (band_gain(0) !== 13'd336) begin
      n_fails++;
      $display("[TB] FAIL collision_pre gain actual=%0d required=336", band_gain(0));
    end
    sb_q.push_back('{0, ref_gain(1)});
    applyStimulus(0, 1);
    @(posedge clk);
    #1;
    sample_tick = 1'b1;
    @(posedge clk);
    #1;
    sample_tick = 1'b0;
    commit_model();
    step_model();
    n_checks++;
    if (band_gain(0) !== 13'd320 || band_gain(0) !== mdl_cur[0]) begin
      n_fails++;
      $display("[TB] FAIL collision gain actual=%0d required=320", band_gain(0));
    end
    n_checks++;
    if (settled !== exp_settled()) begin
      n_fails++;
      $display("[TB] FAIL collision_settled actual=%h required=%h", settled, exp_settled());
    end
  endtask

  task automatic test_handshake();
    upd_band  = 3'd3;
    upd_code  = 6'd20;
    upd_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      n_checks++;
      if (upd_ready !== ((k % 3 == 0) || k >= 9) || upd_err !== (k == 8)) begin
        n_fails++;
        $display("[TB] FAIL handshake cycle=%0d ready/err actual=%b/%b required=%b/%b", k, upd_ready, upd_err, ((k % 3 == 0) || k >= 9), (k == 8));
      end
      for (int b = 0; b < NB; b++) begin
        n_checks++;
        if (band_gain(b) !== mdl_cur[b]) begin
          n_fails++;
          $display("[TB] FAIL handshake_gain cycle=%0d band=%0d actual=%0d required=%0d", k, b, band_gain(b), mdl_cur[b]);
        end
      end
      n_checks++;
      if (settled !== exp_settled()) begin
        n_fails++;
        $display("[TB] FAIL handshake_settled cycle=%0d actual=%h required=%h", k, settled, exp_settled());
      end
      @(posedge clk);
      #1;
      if (k == 0 || k == 3 || k == 6) sb_q.push_back('{int'(upd_band), ref_gain(int'(upd_code))});
      if (k == 2 || k == 5 || k == 8) commit_model();
      if (k == 3) begin
        upd_band = 3'd7;
        upd_code = 6'd33;
      end
      if (k == 6) upd_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    send_and_commit(4, 25);
`ifdef GAIN_RAMP_EN
    for (int i = 0; i < 3; i++) begin
      tick_once();
      repeat (3) @(posedge clk);
      #1;
    end
`endif
    n_checks++;
    if (band_gain(4) !== mdl_cur[4]) begin
      n_fails++;
      $display("[TB] FAIL pre_reset gain4 actual=%0d required=%0d", band_gain(4), mdl_cur[4]);
    end
    applyStimulus(3, 33);
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int b = 0; b < NB; b++) begin
      n_checks++;
      if (band_gain(b) !== 13'h100) begin
        n_fails++;
        $display("[TB] FAIL mid_reset_gain band=%0d actual=%h required=100", b, band_gain(b));
      end
    end
    n_checks++;
    if (settled !== 5'h1F || upd_ready !== 1'b1 || upd_err !== 1'b0) begin
      n_fails++;
      $display("[TB] FAIL mid_reset_flags settled/ready/err actual=%h/%b/%b required=1f/1/0", settled, upd_ready, upd_err);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (band_gain(3) !== 13'h100 || settled !== 5'h1F) begin
      n_fails++;
      $display("[TB] FAIL abandoned_update gain3/settled actual=%h/%h required=100/1f", band_gain(3), settled);
    end
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
`ifdef GAIN_RAMP_EN
    test_ramp_up();
    test_ramp_down();
    test_collision();
`else
    test_table_sweep();
    test_tick_ignored();
`endif
    test_handshake();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
